if_fetch_queue: RTL

- Parametrised successor to the single-entry fetch stage: decoupled instruction fetch over an SRAM-like req/addr_ok/data_ok bus.
- Supports multiple outstanding requests and an N-entry instruction queue feeding ID.
- Handles redirects (exception, ertn, branch) by flushing the queue and silently discarding stale in-flight responses.
- Sits between the PC/redirect sources and the ID stage.

---
 rtl/if_fetch_queue.sv | 158 +++++++++++++++
 1 files changed

// File: rtl/if_fetch_queue.sv
// Decoupled instruction fetch: multiple outstanding SRAM-like requests feeding an N-entry queue toward ID.
// Optional IF_PERF_CNT_EN adds fetch/drop/stall performance counters.
module if_fetch_queue #(
  parameter logic [31:0] RESET_PC        = 32'h1c000000,
  parameter int          BUF_DEPTH       = 4,
  parameter int          MAX_OUTSTANDING = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        id_allowin,
  output logic        if_id_valid,
  output logic [64:0] if_id_bus,
  input  logic        br_taken,
  input  logic [31:0] br_target,
  input  logic        wb_ex,
  input  logic [31:0] ex_entry,
  input  logic        ertn_flush,
  input  logic [31:0] ertn_entry,
  output logic        inst_sram_req,
  output logic        inst_sram_wr,
  output logic [1:0]  inst_sram_size,
  output logic [3:0]  inst_sram_wstrb,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  input  logic        inst_sram_addr_ok,
  input  logic        inst_sram_data_ok,
  input  logic [31:0] inst_sram_rdata
`ifdef IF_PERF_CNT_EN
  ,
  output logic [31:0] perf_fetch_cnt,
  output logic [31:0] perf_drop_cnt,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int AW = $clog2(BUF_DEPTH);
  localparam int CW = $clog2(BUF_DEPTH + 1);
  localparam int OW = $clog2(MAX_OUTSTANDING + 1);
  localparam int PW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;

  logic [31:0]   fetch_pc_reg;
  logic [CW-1:0] count_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [AW-1:0] wr_ptr_reg;
  logic [OW-1:0] outstanding_reg;
  logic [OW-1:0] discard_reg;
  logic          adef_sent_reg;
  logic [PW-1:0] pend_rd_reg;
  logic [PW-1:0] pend_wr_reg;

  logic [64:0]   queue_mem [BUF_DEPTH];
  logic [31:0]   pend_mem  [MAX_OUTSTANDING];

  logic          redir;
  logic [31:0]   redir_target;
  logic          misaligned;
  logic          room;
  logic          accept;
  logic          resp;
  logic          drop;
  logic          push_data;
  logic          push_adef;
  logic          push;
  logic          pop;
  logic          empty;
  logic [64:0]   push_entry;
  logic [OW-1:0] outstanding_next;
  logic [PW-1:0] pend_rd_next;
  logic [PW-1:0] pend_wr_next;

  always_comb begin
    redir        = wb_ex | ertn_flush | br_taken;
    redir_target = wb_ex ? ex_entry : (ertn_flush ? ertn_entry : br_target);
    misaligned   = |fetch_pc_reg[1:0];
    // Slots for in-flight requests are reserved, so the queue can never overflow on a response.
    room         = (32'(count_reg) + 32'(outstanding_reg)) < 32'(BUF_DEPTH);

    inst_sram_req = ~reset & ~redir & ~adef_sent_reg & ~misaligned
                  & (32'(outstanding_reg) < 32'(MAX_OUTSTANDING)) & room;
    accept        = inst_sram_req & inst_sram_addr_ok;
    resp          = inst_sram_data_ok & (outstanding_reg != '0);
    drop          = resp & (redir | (discard_reg != '0));
    push_data     = resp & ~drop;
    push_adef     = ~redir & misaligned & ~adef_sent_reg & room & ~push_data;
    push          = push_data | push_adef;
    push_entry    = push_adef ? {1'b1, fetch_pc_reg, 32'h0}
                              : {1'b0, pend_mem[pend_rd_reg], inst_sram_rdata};

    empty       = (count_reg == '0);
    if_id_valid = ~empty & ~redir;
    if_id_bus   = empty ? '0 : queue_mem[rd_ptr_reg];
    pop         = if_id_valid & id_allowin;

    outstanding_next = outstanding_reg + OW'(accept) - OW'(resp);
    pend_rd_next = (pend_rd_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : pend_rd_reg + PW'(1);
    pend_wr_next = (pend_wr_reg == PW'(MAX_OUTSTANDING - 1)) ? '0 : pend_wr_reg + PW'(1);
  end

  assign inst_sram_wr    = 1'b0;
  assign inst_sram_size  = 2'b10;
  assign inst_sram_wstrb = 4'h0;
  assign inst_sram_addr  = fetch_pc_reg;
  assign inst_sram_wdata = 32'h0;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetch_pc_reg    <= RESET_PC;
      count_reg       <= '0;
      rd_ptr_reg      <= '0;
      wr_ptr_reg      <= '0;
      outstanding_reg <= '0;
      discard_reg     <= '0;
      adef_sent_reg   <= 1'b0;
      pend_rd_reg     <= '0;
      pend_wr_reg     <= '0;
    end else begin
      outstanding_reg <= outstanding_next;
      if (accept) pend_wr_reg <= pend_wr_next;
      if (resp)   pend_rd_reg <= pend_rd_next;
      if (redir) begin
        fetch_pc_reg  <= redir_target;
        count_reg     <= '0;
        rd_ptr_reg    <= '0;
        wr_ptr_reg    <= '0;
        adef_sent_reg <= 1'b0;
        // Everything still in flight after this cycle belongs to the old path.
        discard_reg   <= outstanding_next;
      end else begin
        if (accept)    fetch_pc_reg  <= fetch_pc_reg + 32'd4;
        if (push_adef) adef_sent_reg <= 1'b1;
        if (drop)      discard_reg   <= discard_reg - OW'(1);
        if (push)      wr_ptr_reg    <= wr_ptr_reg + AW'(1);
        if (pop)       rd_ptr_reg    <= rd_ptr_reg + AW'(1);
        count_reg <= count_reg + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push)   queue_mem[wr_ptr_reg] <= push_entry;
    if (accept) pend_mem[pend_wr_reg] <= fetch_pc_reg;
  end

`ifdef IF_PERF_CNT_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_cnt <= '0;
      perf_drop_cnt  <= '0;
      perf_stall_cnt <= '0;
    end else begin
      if (accept) perf_fetch_cnt <= perf_fetch_cnt + 32'd1;
      if (drop)   perf_drop_cnt  <= perf_drop_cnt + 32'd1;
      if ((count_reg == CW'(BUF_DEPTH)) && !id_allowin) perf_stall_cnt <= perf_stall_cnt + 32'd1;
    end
  end
`endif

endmodule
